// File: rtl/xdisp_scan_pkg.sv
// Shared definitions for the seven-segment scan driver: address map, digit
// register field layout and the active-high seg7 glyph constants.
package xdisp_scan_pkg;

  localparam logic [7:0] DISP_BASE = 8'hF0;
  localparam logic [1:0] DISP_DIG0 = 2'd0;
  localparam logic [1:0] DISP_DIG1 = 2'd1;
  localparam logic [1:0] DISP_DIG2 = 2'd2;
  localparam logic [1:0] DISP_DIG3 = 2'd3;

  localparam int unsigned DIG_VAL_LSB = 0;
  localparam int unsigned DIG_VAL_MSB = 3;
  localparam int unsigned DIG_DP      = 4;
  localparam int unsigned DIG_BLANK   = 5;

  typedef struct packed {
    logic       blank;
    logic       dp;
    logic [3:0] value;
  } dig_t;

  localparam dig_t DIG_RESET = '{blank: 1'b1, dp: 1'b0, value: 4'h0};

  // Active-high {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG7_0 = 7'h3F;
  localparam logic [6:0] SEG7_1 = 7'h06;
  localparam logic [6:0] SEG7_2 = 7'h5B;
  localparam logic [6:0] SEG7_3 = 7'h4F;
  localparam logic [6:0] SEG7_4 = 7'h66;
  localparam logic [6:0] SEG7_5 = 7'h6D;
  localparam logic [6:0] SEG7_6 = 7'h7D;
  localparam logic [6:0] SEG7_7 = 7'h07;
  localparam logic [6:0] SEG7_8 = 7'h7F;
  localparam logic [6:0] SEG7_9 = 7'h6F;
  localparam logic [6:0] SEG7_A = 7'h77;
  localparam logic [6:0] SEG7_B = 7'h7C;
  localparam logic [6:0] SEG7_C = 7'h39;
  localparam logic [6:0] SEG7_D = 7'h5E;
  localparam logic [6:0] SEG7_E = 7'h79;
  localparam logic [6:0] SEG7_F = 7'h71;

  // Board pins are active-low; a blanked digit drives every segment off.
  function automatic logic [7:0] seg_pins(input dig_t d, input logic [6:0] seg);
    if (d.blank) return 8'hFF;
    return {~d.dp, ~seg};
  endfunction

endpackage

// File: rtl/xdisp_scan_seg7.sv
// Pure combinational hex-to-seven-segment decoder (active-high segments).
module xseg7_decode
  import xdisp_scan_pkg::*;
(
  input  logic [3:0] i_val,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = '0;
    unique case (i_val)
      4'h0: o_seg = SEG7_0;
      4'h1: o_seg = SEG7_1;
      4'h2: o_seg = SEG7_2;
      4'h3: o_seg = SEG7_3;
      4'h4: o_seg = SEG7_4;
      4'h5: o_seg = SEG7_5;
      4'h6: o_seg = SEG7_6;
      4'h7: o_seg = SEG7_7;
      4'h8: o_seg = SEG7_8;
      4'h9: o_seg = SEG7_9;
      4'hA: o_seg = SEG7_A;
      4'hB: o_seg = SEG7_B;
      4'hC: o_seg = SEG7_C;
      4'hD: o_seg = SEG7_D;
      4'hE: o_seg = SEG7_E;
      4'hF: o_seg = SEG7_F;
      default: o_seg = '0;
    endcase
  end

endmodule

// File: rtl/xdisp_scan.sv
// Memory-mapped 4-digit seven-segment scan driver: digit register file,
// refresh counter with anti-ghosting guard, registered pin outputs.
module xdisp_scan
  import xdisp_scan_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD       = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic [7:0] Disp,
  output logic [3:0] Disp_sel
);

  localparam int unsigned    CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]  CNT_LAST = CW'(REFRESH_DIV - 1);

  dig_t          r_dig [4];
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;

  dig_t          w_cur;
  logic [6:0]    w_seg;
  logic          w_guard;
  logic          w_unused_hi;

  assign w_unused_hi = ^data_in[7:6];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) r_dig[i] <= DIG_RESET;
    end else if (sel && we) begin
      r_dig[addr] <= dig_t'(data_in[DIG_BLANK:DIG_VAL_LSB]);
    end
  end

  // Reads sample the pre-write contents, so a same-cycle write shows up one cycle later.
  always_ff @(posedge clk) begin
    if (rst) data_out <= '0;
    else     data_out <= {2'b00, r_dig[addr]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  generate
    if (GUARD == 0) begin : g_no_guard
      assign w_guard = 1'b0;
    end else begin : g_guard
      localparam logic [CW-1:0] GUARD_CNT = CW'(GUARD);
      assign w_guard = (r_cnt < GUARD_CNT);
    end
  endgenerate

  assign w_cur = r_dig[r_idx];

  xseg7_decode u_seg7 (
    .i_val (w_cur.value),
    .o_seg (w_seg)
  );

  always_ff @(posedge clk) begin
    if (rst || w_guard) begin
      Disp_sel <= 4'hF;
      Disp     <= 8'hFF;
    end else begin
      Disp_sel <= ~(4'b0001 << r_idx);
      Disp     <= seg_pins(w_cur, w_seg);
    end
  end

endmodule

// File: tb/tb_xdisp_scan.sv
// Directed bench for xdisp_scan: one instance with REFRESH_DIV=8/GUARD=2,
// a second with GUARD=0 sharing the same bus and reset.
module tb_xdisp_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic       we;
  logic [1:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out, data_out0;
  logic [7:0] Disp, Disp0;
  logic [3:0] Disp_sel, Disp_sel0;

  int tests = 0;
  int fails = 0;
  int n     = 0;

  localparam logic [3:0] SEL_TBL  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  localparam logic [7:0] SCAN_TBL [4] = '{8'hF9, 8'hA4, 8'h08, 8'h8E};
  localparam logic [7:0] WRAP_TBL [4] = '{8'hF9, 8'h80, 8'hFF, 8'h46};

  xdisp_scan #(.REFRESH_DIV(8), .GUARD(2)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .data_in(data_in),
    .data_out(data_out), .Disp(Disp), .Disp_sel(Disp_sel)
  );

  xdisp_scan #(.REFRESH_DIV(8), .GUARD(0)) dut0 (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .data_in(data_in),
    .data_out(data_out0), .Disp(Disp0), .Disp_sel(Disp_sel0)
  );

  always #5 clk = ~clk;

  // n = edges since the last reset edge; edge n shows cnt=(n-1)%8, idx=((n-1)/8)%4
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) n = 0;
    else     n++;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    sel = 1'b1; we = 1'b1; addr = a; data_in = d;
    tick();
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic wait_frame_start();
    for (int k = 0; k < 32 && (n % 32) != 0; k++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tests++;
    if (Disp !== 8'hFF || Disp_sel !== 4'hF || data_out !== 8'h00) begin
      fails++;
      $display("FAIL reset_out: Disp=%h Disp_sel=%h data_out=%h, want FF F 00", Disp, Disp_sel, data_out);
    end
    rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      tick();
      tests++;
      if (data_out !== 8'h20) begin
        fails++;
        $display("FAIL reset_read[%0d]: got %h want 20", a, data_out);
      end
    end
  endtask

  task automatic test_write_scan();
    wr(2'd0, 8'h01);
    wr(2'd1, 8'h02);
    wr(2'd2, 8'h1A);
    wr(2'd3, 8'h0F);
    wait_frame_start();
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 8; c++) begin
        tick();
        tests++;
        if (c < 2) begin
          if (Disp_sel !== 4'hF || Disp !== 8'hFF) begin
            fails++;
            $display("FAIL scan_guard slot%0d c%0d: sel=%h disp=%h want F FF", k, c, Disp_sel, Disp);
          end
        end else if (Disp_sel !== SEL_TBL[k] || Disp !== SCAN_TBL[k]) begin
          fails++;
          $display("FAIL scan_digit slot%0d c%0d: sel=%h disp=%h want %h %h",
                   k, c, Disp_sel, Disp, SEL_TBL[k], SCAN_TBL[k]);
        end
      end
    end
  endtask

  task automatic test_blank();
    wr(2'd2, 8'h25);
    addr = 2'd2;
    tick();
    tests++;
    if (data_out !== 8'h25) begin
      fails++;
      $display("FAIL blank_read: got %h want 25", data_out);
    end
    wait_frame_start();
    for (int k = 0; k < 18; k++) tick();
    for (int c = 2; c < 8; c++) begin
      tick();
      tests++;
      if (Disp_sel !== 4'hB || Disp !== 8'hFF) begin
        fails++;
        $display("FAIL blank_slot c%0d: sel=%h disp=%h want B FF", c, Disp_sel, Disp);
      end
    end
  endtask

  task automatic test_mid_slot_write();
    wait_frame_start();
    for (int k = 0; k < 11; k++) tick();
    tests++;
    if (Disp_sel !== 4'hD || Disp !== 8'hA4) begin
      fails++;
      $display("FAIL midslot_before: sel=%h disp=%h want D A4", Disp_sel, Disp);
    end
    wr(2'd1, 8'h08);
    tests++;
    if (Disp !== 8'hA4) begin
      fails++;
      $display("FAIL midslot_write_edge: disp=%h want A4", Disp);
    end
    tick();
    tests++;
    if (Disp_sel !== 4'hD || Disp !== 8'h80) begin
      fails++;
      $display("FAIL midslot_after: sel=%h disp=%h want D 80", Disp_sel, Disp);
    end
  endtask

  task automatic test_read_after_write();
    wr(2'd3, 8'h1C);
    tests++;
    if (data_out !== 8'h0F) begin
      fails++;
      $display("FAIL raw_old: got %h want 0F", data_out);
    end
    tick();
    tests++;
    if (data_out !== 8'h1C) begin
      fails++;
      $display("FAIL raw_new: got %h want 1C", data_out);
    end
  endtask

  task automatic test_wrap_guard0();
    wait_frame_start();
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) begin
        for (int c = 0; c < 8; c++) begin
          tick();
          tests++;
          if (Disp_sel0 !== SEL_TBL[k] || Disp0 !== WRAP_TBL[k]) begin
            fails++;
            $display("FAIL wrap_g0 f%0d slot%0d c%0d: sel=%h disp=%h want %h %h",
                     f, k, c, Disp_sel0, Disp0, SEL_TBL[k], WRAP_TBL[k]);
          end
        end
      end
    end
  endtask

  task automatic test_mid_scan_reset();
    for (int k = 0; k < 13; k++) tick();
    rst = 1'b1;
    tick();
    tests++;
    if (Disp !== 8'hFF || Disp_sel !== 4'hF || data_out !== 8'h00 || Disp_sel0 !== 4'hF) begin
      fails++;
      $display("FAIL midreset_out: Disp=%h sel=%h dout=%h sel0=%h want FF F 00 F",
               Disp, Disp_sel, data_out, Disp_sel0);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (Disp_sel !== 4'hF || Disp_sel0 !== 4'hE) begin
      fails++;
      $display("FAIL post_reset_e1: sel=%h sel0=%h want F E", Disp_sel, Disp_sel0);
    end
    tick();
    tests++;
    if (Disp_sel !== 4'hF) begin
      fails++;
      $display("FAIL post_reset_e2: sel=%h want F", Disp_sel);
    end
    tick();
    tests++;
    if (Disp_sel !== 4'hE || Disp !== 8'hFF) begin
      fails++;
      $display("FAIL post_reset_e3: sel=%h disp=%h want E FF", Disp_sel, Disp);
    end
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      tick();
      tests++;
      if (data_out !== 8'h20 || data_out0 !== 8'h20) begin
        fails++;
        $display("FAIL midreset_read[%0d]: got %h/%h want 20", a, data_out, data_out0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; data_in = '0;
    test_reset();
    test_write_scan();
    test_blank();
    test_mid_slot_write();
    test_read_after_write();
    test_wrap_guard0();
    test_mid_scan_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
